// File: rtl/ternary_neuron_accum_if.sv
// Stream bundle for the ternary neuron accumulator: partial-sum input stream
// and one-result-per-frame output stream.
interface ternary_neuron_accum_if #(
    parameter int SUM_W = 3,
    parameter int ACC_W = 8,
    parameter int CNT_W = 8
);
    // Both streams use strict valid/ready: a transfer happens on a rising edge
    // where valid & ready are both 1; a producer holding valid keeps its payload
    // stable until that edge, and ready never depends on valid.
    logic             in_valid;
    logic             in_ready;
    logic [SUM_W-1:0] in_sum;
    logic             in_last;
    logic [ACC_W-1:0] threshold;
    logic             out_valid;
    logic             out_ready;
    logic             out_spike;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_sum, in_last, threshold, out_ready,
        input  in_ready, out_valid, out_spike, out_acc, out_count
    );

    modport slave (
        input  in_valid, in_sum, in_last, threshold, out_ready,
        output in_ready, out_valid, out_spike, out_acc, out_count
    );
endinterface

// File: rtl/ternary_neuron_accum.sv
// Accumulates signed synapse partial sums over a frame with saturation and
// emits one thresholded spike per frame, held until downstream takes it.
module ternary_neuron_accum #(
    parameter int SUM_W = 3,
    parameter int ACC_W = 8,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    ternary_neuron_accum_if.slave  bus,
    output logic                   dbg_state
);
    typedef enum logic {
        ACCUM = 1'b0,
        FIRE  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             spike_q;
    logic [ACC_W-1:0] out_acc_q;
    logic [CNT_W-1:0] out_cnt_q;

    logic                    accept;
    logic signed [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0]        sat_sum;
    logic [CNT_W-1:0]        cnt_inc;
    logic                    fire_hit;

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == FIRE);
    assign bus.out_spike = spike_q;
    assign bus.out_acc   = out_acc_q;
    assign bus.out_count = out_cnt_q;
    assign dbg_state     = state_q;

    assign accept = bus.in_valid && (state_q == ACCUM);

    // One extra bit of headroom: if the top two bits differ the sum overflowed
    // and the top bit tells which rail to clamp to.
    always_comb begin
        sum_wide = $signed({{(ACC_W + 1 - SUM_W){bus.in_sum[SUM_W-1]}}, bus.in_sum})
                 + $signed({acc_q[ACC_W-1], acc_q});
        sat_sum  = sum_wide[ACC_W-1:0];
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            sat_sum = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}};
        end
        cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        fire_hit = ($signed(sat_sum) >= $signed(bus.threshold));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (accept && bus.in_last) state_d = FIRE;
            FIRE:    if (bus.out_ready)         state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ACCUM;
        else     state_q <= state_d;
    end

    // Result registers only change on a last beat, so they stay stable in FIRE
    // and keep their values after the result is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            spike_q   <= 1'b0;
            out_acc_q <= '0;
            out_cnt_q <= '0;
        end else if (accept) begin
            if (bus.in_last) begin
                out_acc_q <= sat_sum;
                out_cnt_q <= cnt_inc;
                spike_q   <= fire_hit;
                acc_q     <= '0;
                cnt_q     <= '0;
            end else begin
                acc_q <= sat_sum;
                cnt_q <= cnt_inc;
            end
        end
    end
endmodule

// File: tb/tb_ternary_neuron_accum.sv
// Directed bench for ternary_neuron_accum: frame arithmetic, saturation,
// backpressure, reset behaviour and count saturation with input gaps.
module tb_ternary_neuron_accum;
    logic clk;
    logic rst;
    logic dbg_state;
    int   checks = 0;
    int   errors = 0;

    ternary_neuron_accum_if #(.SUM_W(3), .ACC_W(8), .CNT_W(8)) bus ();

    ternary_neuron_accum #(.SUM_W(3), .ACC_W(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send_beat(input int s, input logic last);
        int waits = 0;
        bus.in_valid = 1'b1;
        bus.in_sum   = 3'(s);
        bus.in_last  = last;
        while (!bus.in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        check("ready_wait", int'(waits < 50), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sum   = 3'bxxx;
        bus.in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input int acc, input int cnt, input int spk);
        check({tag, "_valid"}, int'(bus.out_valid), 1);
        check({tag, "_acc"},   int'($signed(bus.out_acc)), acc);
        check({tag, "_count"}, int'(bus.out_count), cnt);
        check({tag, "_spike"}, int'(bus.out_spike), spk);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sum    = 3'b000;
        bus.in_last   = 1'b0;
        bus.threshold = 8'd0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_in_ready",  int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_spike",     int'(bus.out_spike), 0);
        check("rst_acc",       int'(bus.out_acc), 0);
        check("rst_count",     int'(bus.out_count), 0);
        check("rst_state",     int'(dbg_state), 0);

        // +1 +2 -1, threshold 2
        bus.threshold = 8'd2;
        bus.out_ready = 1'b1;
        send_beat(1, 1'b0);
        send_beat(2, 1'b0);
        send_beat(-1, 1'b1);
        check_result("f1", 2, 3, 1);
        check("f1_ready_in_fire", int'(bus.in_ready), 0);
        @(negedge clk);
        check("f1_valid_drop", int'(bus.out_valid), 0);
        check("f1_acc_hold", int'($signed(bus.out_acc)), 2);

        // same frame, threshold 3
        bus.threshold = 8'd3;
        send_beat(1, 1'b0);
        send_beat(2, 1'b0);
        send_beat(-1, 1'b1);
        check_result("f2", 2, 3, 0);
        @(negedge clk);

        // single-beat frame
        bus.threshold = -8'sd2;
        send_beat(-2, 1'b1);
        check_result("single", -2, 1, 1);
        @(negedge clk);

        // positive saturation
        bus.threshold = 8'd100;
        for (int i = 0; i < 70; i++) send_beat(2, 1'b0);
        send_beat(-2, 1'b1);
        check_result("sat_pos", 125, 71, 1);
        @(negedge clk);

        // negative saturation
        for (int i = 0; i < 70; i++) send_beat(-2, 1'b0);
        send_beat(-2, 1'b1);
        check_result("sat_neg", -128, 71, 0);
        @(negedge clk);

        // backpressure
        bus.threshold = 8'd0;
        bus.out_ready = 1'b0;
        send_beat(1, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_sum   = 3'd2;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", int'(bus.in_ready), 0);
            check_result("bp_hold", 1, 1, 1);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_after_hs_ready", int'(bus.in_ready), 1);
        check("bp_after_hs_valid", int'(bus.out_valid), 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check_result("bp_next", 2, 1, 1);
        @(negedge clk);
        check("bp_next_drop", int'(bus.out_valid), 0);

        // reset mid-frame discards partial sum
        bus.threshold = 8'd1;
        send_beat(2, 1'b0);
        send_beat(2, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_beat(1, 1'b1);
        check_result("rst_mid", 1, 1, 1);
        @(negedge clk);

        // reset while in FIRE drops the pending result
        bus.out_ready = 1'b0;
        send_beat(2, 1'b1);
        check("fire_before_rst", int'(bus.out_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("fire_rst_valid", int'(bus.out_valid), 0);
        check("fire_rst_acc",   int'(bus.out_acc), 0);
        check("fire_rst_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        check("fire_rst_stay", int'(bus.out_valid), 0);

        // 300 zero beats with random gaps: count saturates
        bus.out_ready = 1'b1;
        bus.threshold = 8'd0;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_beat(0, (i == 299));
        end
        check_result("gap_sat", 0, 255, 1);
        @(negedge clk);
        check("gap_drop", int'(bus.out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
